// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port 32-bit data memory behind a valid/ready request
// port, with a fixed number of wait states per access.
//   clk                 sole clock, rising edge
//   rst                 synchronous reset, active low; clears state and memory
//   reqValid/reqReady   request handshake (ready only while idle)
//   reqWrite/reqAddr/reqSize/reqSigned/reqWdata   request fields, latched on handshake
//   respValid/respData/respErr   one-cycle response strobe, data/error qualified by it
//   busy                request in flight
//   dbgWordAddr/dbgData combinational debug read of one memory word
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [31:0]           reqAddr,
    input  logic [1:0]            reqSize,
    input  logic                  reqSigned,
    input  logic [31:0]           reqWdata,
    output logic                  respValid,
    output logic [31:0]           respData,
    output logic                  respErr,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] dbgWordAddr,
    output logic [31:0]           dbgData
);

    localparam int          DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0]  WS_C  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Illegal size, or a half/word access not aligned to its own size.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = off[0];
            2'd2:    bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pick the addressed byte/half out of a memory word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'd0:    r = {{24{sgn & b[7]}}, b};
            2'd1:    r = {{16{sgn & h[15]}}, h};
            2'd2:    r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Merge right-aligned store data into the addressed lanes of the old word.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        case (size)
            2'd0:    r[{off, 3'b000} +: 8]    = wd[7:0];
            2'd1:    r[{off[1], 4'b0000} +: 16] = wd[15:0];
            2'd2:    r = wd;
            default: r = old;
        endcase
        return r;
    endfunction

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [31:0]             resp_data_q, resp_data_d;
    logic                    resp_err_q, resp_err_d;
    logic                    op_write_q, op_signed_q;
    logic [ADDR_WIDTH+1:0]   op_addr_q;
    logic [1:0]              op_size_q;
    logic [31:0]             op_wdata_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    hs_s, in_idle_s, access_s, err_s;
    logic                    cur_write_s, cur_signed_s;
    logic [ADDR_WIDTH+1:0]   cur_addr_s;
    logic [1:0]              cur_size_s;
    logic [31:0]             cur_wdata_s, rd_word_s, wr_word_s;
    logic [ADDR_WIDTH-1:0]   idx_s;
    logic                    unused_addr_s;

    // Upper address bits alias onto the word array by design.
    assign unused_addr_s = ^reqAddr[31:ADDR_WIDTH+2];

    assign in_idle_s = (state_q == IDLE);
    assign reqReady  = in_idle_s && rst;
    assign hs_s      = reqValid && reqReady;

    // With zero wait states the access happens on the handshake edge itself, so
    // the live request fields are used while idle and the latched copy otherwise.
    assign cur_write_s  = in_idle_s ? reqWrite                  : op_write_q;
    assign cur_signed_s = in_idle_s ? reqSigned                 : op_signed_q;
    assign cur_addr_s   = in_idle_s ? reqAddr[ADDR_WIDTH+1:0]   : op_addr_q;
    assign cur_size_s   = in_idle_s ? reqSize                   : op_size_q;
    assign cur_wdata_s  = in_idle_s ? reqWdata                  : op_wdata_q;

    assign err_s     = is_bad_access(cur_size_s, cur_addr_s[1:0]);
    assign idx_s     = cur_addr_s[ADDR_WIDTH+1:2];
    assign rd_word_s = mem_q[idx_s];
    assign wr_word_s = store_merge(rd_word_s, cur_wdata_s, cur_size_s, cur_addr_s[1:0]);

    assign respValid = resp_valid_q;
    assign respData  = resp_data_q;
    assign respErr   = resp_err_q;
    assign busy      = !in_idle_s;
    assign dbgData   = mem_q[dbgWordAddr];

    // Next-state, wait counter and response register values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_data_d  = 32'd0;
        resp_err_d   = 1'b0;
        access_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    if (err_s) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (WS_C == 4'd0) begin
                        state_d  = RESP;
                        access_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS_C;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d  = RESP;
                    cnt_d    = 4'd0;
                    access_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (access_s) begin
            resp_valid_d = 1'b1;
            if (cur_write_s) begin
                resp_data_d = 32'd0;
            end else begin
                resp_data_d = load_extract(rd_word_s, cur_size_s, cur_addr_s[1:0], cur_signed_s);
            end
        end else begin
            resp_valid_d = resp_valid_d;
        end
    end

    // State, request latch, response registers and memory array.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_err_q   <= 1'b0;
            op_write_q   <= 1'b0;
            op_signed_q  <= 1'b0;
            op_addr_q    <= '0;
            op_size_q    <= 2'd0;
            op_wdata_q   <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            if (hs_s) begin
                op_write_q  <= reqWrite;
                op_signed_q <= reqSigned;
                op_addr_q   <= reqAddr[ADDR_WIDTH+1:0];
                op_size_q   <= reqSize;
                op_wdata_q  <= reqWdata;
            end
            if (access_s && cur_write_s) begin
                mem_q[idx_s] <= wr_word_s;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: one instance with two wait states,
// one with none; byte-array reference model of the memory.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv2, rv0;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqWdata;
    logic [7:0]  dbgWordAddr;
    logic        rdy2, vld2, err2, busy2;
    logic [31:0] dat2, dbg2;
    logic        rdy0, vld0, err0, busy0;
    logic [31:0] dat0, dbg0;

    int checks = 0;
    int errors = 0;
    int quiet_viol = 0;
    logic [7:0] mem_b [0:1023];

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .reqValid(rv2), .reqReady(rdy2), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqSize(reqSize), .reqSigned(reqSigned), .reqWdata(reqWdata),
        .respValid(vld2), .respData(dat2), .respErr(err2), .busy(busy2),
        .dbgWordAddr(dbgWordAddr), .dbgData(dbg2)
    );

    data_mem_ctrl #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .reqValid(rv0), .reqReady(rdy0), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqSize(reqSize), .reqSigned(reqSigned), .reqWdata(reqWdata),
        .respValid(vld0), .respData(dat0), .respErr(err0), .busy(busy0),
        .dbgWordAddr(dbgWordAddr), .dbgData(dbg0)
    );

    // ---------------- reference model (byte addressed, 1 KiB, aliasing) ----------------
    function automatic bit m_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int n = 1 << sz;
        int base = int'(a % 1024);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(mem_b[base + k]) << (8 * k));
        if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] m_word(input int w);
        return {mem_b[4 * w + 3], mem_b[4 * w + 2], mem_b[4 * w + 1], mem_b[4 * w]};
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n = 1 << sz;
        int base = int'(a % 1024);
        for (int k = 0; k < n; k++) mem_b[base + k] = 8'((wd >> (8 * k)) & 32'hFF);
    endtask

    task automatic m_clear();
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'd0;
    endtask

    // ---------------- driver for the two-wait-state instance ----------------
    task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic sg,
                          input logic [31:0] wd, output logic [31:0] rdata, output logic rerr,
                          output int lat);
        @(negedge clk);
        reqWrite = w; reqAddr = a; reqSize = sz; reqSigned = sg; reqWdata = wd; rv2 = 1'b1;
        for (int i = 0; i < 6 && !rdy2; i++) @(negedge clk);
        @(posedge clk);
        #1;
        rv2 = 1'b0;
        // scramble the request bus: the controller must work from its latched copy
        reqWrite = 1'($urandom); reqAddr = $urandom; reqSize = 2'($urandom);
        reqSigned = 1'($urandom); reqWdata = $urandom;
        lat = 0; rdata = 32'd0; rerr = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (vld2) begin
                lat = i; rdata = dat2; rerr = err2;
                break;
            end else if (dat2 !== 32'd0 || err2 !== 1'b0) begin
                quiet_viol++;
            end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout addr=%h got no respValid within 20 cycles", a);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; rv2 = 1'b0; rv0 = 1'b0; reqWrite = 1'b0; reqAddr = 32'd0;
        reqSize = 2'd0; reqSigned = 1'b0; reqWdata = 32'd0; dbgWordAddr = 8'd5;
        m_clear();
        repeat (2) @(negedge clk);
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", rdy2); end
        checks++; if (vld2 !== 1'b0 || dat2 !== 32'd0 || err2 !== 1'b0) begin
            errors++; $display("FAIL rst_resp got v=%b d=%h e=%b exp 0/0/0", vld2, dat2, err2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy2); end
        checks++; if (dbg2 !== 32'd0) begin errors++; $display("FAIL rst_mem got %h exp 0", dbg2); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rdy2 !== 1'b1 || rdy0 !== 1'b1) begin
            errors++; $display("FAIL rst_release_ready got %b/%b exp 1/1", rdy2, rdy0); end
    endtask

    task automatic test_word_store_load();
        logic [31:0] d; logic e; int l;
        do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, d, e, l);
        m_store(32'h10, 2'd2, 32'hDEADBEEF);
        checks++; if (l != 3) begin errors++; $display("FAIL sw_latency got %0d exp 3", l); end
        checks++; if (d !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL sw_resp got d=%h e=%b exp 0/0", d, e); end
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, d, e, l);
        checks++; if (l != 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", l); end
        checks++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++; $display("FAIL lw_data got d=%h e=%b exp deadbeef/0", d, e); end
    endtask

    task automatic test_byte_signed();
        logic [31:0] d; logic e; int l;
        do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'h0, d, e, l);
        m_store(32'h10, 2'd2, 32'h0);
        do_req(1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_0080, d, e, l);
        m_store(32'h13, 2'd0, 32'h80);
        do_req(1'b0, 32'h13, 2'd0, 1'b1, 32'd0, d, e, l);
        checks++; if (d !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed got %h exp ffffff80", d); end
        do_req(1'b0, 32'h13, 2'd0, 1'b0, 32'd0, d, e, l);
        checks++; if (d !== 32'h0000_0080) begin errors++; $display("FAIL lb_unsigned got %h exp 00000080", d); end
        dbgWordAddr = 8'd4; #1;
        checks++; if (dbg2 !== 32'h8000_0000) begin errors++; $display("FAIL sb_dbg got %h exp 80000000", dbg2); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int l;
        do_req(1'b0, 32'h11, 2'd1, 1'b1, 32'd0, d, e, l);
        checks++; if (l != 1 || e !== 1'b1 || d !== 32'd0) begin
            errors++; $display("FAIL err_half got lat=%0d e=%b d=%h exp 1/1/0", l, e, d); end
        do_req(1'b0, 32'h10, 2'd3, 1'b0, 32'd0, d, e, l);
        checks++; if (l != 1 || e !== 1'b1 || d !== 32'd0) begin
            errors++; $display("FAIL err_size3 got lat=%0d e=%b d=%h exp 1/1/0", l, e, d); end
        do_req(1'b1, 32'h12, 2'd2, 1'b0, 32'h5555_AAAA, d, e, l);
        checks++; if (l != 1 || e !== 1'b1) begin errors++; $display("FAIL err_word_st got lat=%0d e=%b exp 1/1", l, e); end
        dbgWordAddr = 8'd4; #1;
        checks++; if (dbg2 !== m_word(4)) begin errors++; $display("FAIL err_mem_kept got %h exp %h", dbg2, m_word(4)); end
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic e; int l;
        do_req(1'b1, 32'h400, 2'd2, 1'b0, 32'h1234_5678, d, e, l);
        m_store(32'h400, 2'd2, 32'h1234_5678);
        dbgWordAddr = 8'd0; #1;
        checks++; if (dbg2 !== 32'h1234_5678) begin errors++; $display("FAIL wrap_dbg got %h exp 12345678", dbg2); end
    endtask

    task automatic test_random();
        logic [31:0] d, a, wd, exp_d; logic e, w, sg, exp_e; logic [1:0] sz; int l, exp_l, wi;
        quiet_viol = 0;
        for (int it = 0; it < 80; it++) begin
            a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            wd = $urandom;
            exp_e = m_err(sz, a);
            exp_l = exp_e ? 1 : 3;
            exp_d = (exp_e || w) ? 32'd0 : m_load(a, sz, sg);
            do_req(w, a, sz, sg, wd, d, e, l);
            if (!exp_e && w) m_store(a, sz, wd);
            checks++; if (l != exp_l || e !== exp_e || d !== exp_d) begin
                errors++;
                $display("FAIL rand_%0d a=%h sz=%0d w=%b got lat=%0d e=%b d=%h exp lat=%0d e=%b d=%h",
                         it, a, sz, w, l, e, d, exp_l, exp_e, exp_d);
            end
            if (it % 8 == 7) begin
                wi = $urandom_range(0, 15);
                dbgWordAddr = 8'(wi); #1;
                checks++; if (dbg2 !== m_word(wi)) begin
                    errors++; $display("FAIL rand_dbg word %0d got %h exp %h", wi, dbg2, m_word(wi)); end
            end
        end
        checks++; if (quiet_viol != 0) begin
            errors++; $display("FAIL resp_quiet got %0d nonzero idle samples exp 0", quiet_viol); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; int l; int seen;
        do_req(1'b1, 32'h20, 2'd2, 1'b0, 32'hAAAA_5555, d, e, l);
        m_store(32'h20, 2'd2, 32'hAAAA_5555);
        dbgWordAddr = 8'd8; #1;
        checks++; if (dbg2 !== 32'hAAAA_5555) begin errors++; $display("FAIL rm_pre got %h exp aaaa5555", dbg2); end
        @(negedge clk);
        reqWrite = 1'b1; reqAddr = 32'h20; reqSize = 2'd2; reqWdata = 32'h1111_1111; rv2 = 1'b1;
        @(posedge clk); #1; rv2 = 1'b0;
        @(negedge clk);
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL rm_busy got %b exp 1", busy2); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (vld2 !== 1'b0 || rdy2 !== 1'b0 || busy2 !== 1'b0) begin
            errors++; $display("FAIL rm_in_reset got v=%b r=%b b=%b exp 0/0/0", vld2, rdy2, busy2); end
        checks++; if (dbg2 !== 32'd0) begin errors++; $display("FAIL rm_mem got %h exp 0", dbg2); end
        rst = 1'b1;
        m_clear();
        @(negedge clk);
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", rdy2); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (vld2 !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0 || dbg2 !== 32'd0) begin
            errors++; $display("FAIL rm_no_resp got %0d strobes mem=%h exp 0/0", seen, dbg2); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ld;
        // store into the zero-wait instance, then hammer it with loads
        @(negedge clk);
        reqWrite = 1'b1; reqAddr = 32'h0; reqSize = 2'd2; reqSigned = 1'b0; reqWdata = 32'hCAFE_F00D; rv0 = 1'b1;
        @(posedge clk); #1; rv0 = 1'b0;
        @(negedge clk);
        checks++; if (vld0 !== 1'b1 || err0 !== 1'b0) begin
            errors++; $display("FAIL b2b_store got v=%b e=%b exp 1/0", vld0, err0); end
        @(negedge clk);
        reqWrite = 1'b0; reqAddr = 32'h0; reqSize = 2'd2; rv0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (rdy0 !== 1'(i % 2 == 0) || vld0 !== 1'(i % 2 == 1) || busy0 !== 1'(i % 2 == 1) ||
                (i % 2 == 1 && dat0 !== 32'hCAFE_F00D)) begin
                errors++;
                $display("FAIL b2b_ws0_%0d got r=%b v=%b b=%b d=%h exp r=%b v=%b d=cafef00d",
                         i, rdy0, vld0, busy0, dat0, i % 2 == 0, i % 2 == 1);
            end
            @(negedge clk);
        end
        rv0 = 1'b0;
        // two-wait-state instance with reqValid held: one accept per four cycles
        ld = m_load(32'h10, 2'd2, 1'b0);
        @(negedge clk);
        reqWrite = 1'b0; reqAddr = 32'h10; reqSize = 2'd2; rv2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (rdy2 !== 1'(i % 4 == 0) || vld2 !== 1'(i % 4 == 3) || (i % 4 == 3 && dat2 !== ld)) begin
                errors++;
                $display("FAIL b2b_ws2_%0d got r=%b v=%b d=%h exp r=%b v=%b d=%h",
                         i, rdy2, vld2, dat2, i % 4 == 0, i % 4 == 3, ld);
            end
            @(negedge clk);
        end
        rv2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_signed();
        test_errors();
        test_wrap();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
